hazard_ctl: RTL and testbench

- Interlock and stall controller for the 5-stage pipeline.
- The forwarding logic resolves EX-stage register dependencies it can satisfy. This block handles the cases forwarding cannot: load-use bubbles, memory-busy freezes, redirect flushes and halt.
- It keeps its own shadow copy of the destination-register info for the EX, MEM and WB stages. It drives the pipeline-register enable, bubble and flush controls.
- Sits beside the decode stage; consumes ID-stage decode fields plus EX and memory status.

---
 rtl/hazard_ctl_if.sv | 38 +++
 rtl/hazard_ctl.sv | 99 +++++++++
 tb/tb_hazard_ctl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctl_if.sv
// Decode-side hazard interface: ID decode fields and EX/memory status in,
// pipeline-register enable / bubble / flush controls out.
interface hazard_ctl_if #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rX;
    logic [REG_W-1:0] id_rY;
    logic             id_uses_x;
    logic             id_uses_y;
    logic [REG_W-1:0] id_rO;
    logic             id_rf_wen;
    logic             id_is_load;
    logic             id_is_halt;
    logic             ex_redirect;
    logic             mem_busy;
    logic             stall_pc;
    logic             stall_ifid;
    logic             bubble_idex;
    logic             flush_ifid;
    logic             freeze_all;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rX, id_rY, id_uses_x, id_uses_y, id_rO, id_rf_wen,
               id_is_load, id_is_halt, ex_redirect, mem_busy,
        input  stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze_all,
               halted, stall_cnt
    );

    modport slave (
        input  id_rX, id_rY, id_uses_x, id_uses_y, id_rO, id_rf_wen,
               id_is_load, id_is_halt, ex_redirect, mem_busy,
        output stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze_all,
               halted, stall_cnt
    );
endinterface

// File: rtl/hazard_ctl.sv
// Interlock/stall controller: tracks EX/MEM/WB destination info and resolves
// load-use bubbles, memory-busy freezes, redirect flushes and HALT retirement.
module hazard_ctl #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
) (
    input logic         clk,
    input logic         rst,
    hazard_ctl_if.slave hif
);
    typedef struct packed {
        logic [REG_W-1:0] r_o;
        logic             wen;
        logic             load;
        logic             halt;
    } stage_t;

    stage_t           ex_q, mem_q, wb_q;
    stage_t           ex_d, mem_d, wb_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic load_use;
    logic frozen;
    logic stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze_all;

    // Only a load still in EX is unforwardable; MEM/WB loads are bypassed.
    always_comb begin
        load_use = ex_q.load && ex_q.wen &&
                   ((hif.id_uses_x && (hif.id_rX == ex_q.r_o)) ||
                    (hif.id_uses_y && (hif.id_rY == ex_q.r_o)));
        frozen   = halted_q || hif.mem_busy;
    end

    always_comb begin
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        freeze_all  = 1'b0;
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        halted_d    = halted_q;
        cnt_d       = cnt_q;

        if (!rst) begin
            if (frozen) begin
                freeze_all = 1'b1;
            end else begin
                if (hif.ex_redirect) begin
                    flush_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                end else if (load_use) begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                    cnt_d       = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                end

                wb_d  = mem_q;
                mem_d = ex_q;
                if (bubble_idex)
                    ex_d = '0;
                else
                    ex_d = '{r_o: hif.id_rO, wen: hif.id_rf_wen,
                             load: hif.id_is_load, halt: hif.id_is_halt};

                if (wb_q.halt)
                    halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            ex_q     <= ex_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    // Registered outputs are masked too so every output reads 0 while rst is high.
    assign hif.stall_pc    = stall_pc;
    assign hif.stall_ifid  = stall_ifid;
    assign hif.bubble_idex = bubble_idex;
    assign hif.flush_ifid  = flush_ifid;
    assign hif.freeze_all  = freeze_all;
    assign hif.halted      = halted_q && !rst;
    assign hif.stall_cnt   = cnt_q & {CNT_W{!rst}};
endmodule

// File: tb/tb_hazard_ctl.sv
// Scoreboard bench for hazard_ctl: driver pushes model-predicted outputs each
// cycle, monitor pops and compares against the DUT just before the next edge.
module tb_hazard_ctl;
    localparam int REG_W   = 3;
    localparam int CNT_W   = 10;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hif ();
    hazard_ctl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .hif(hif));

    typedef struct {
        int rd;
        bit wen;
        bit ld;
        bit hlt;
    } instr_t;

    typedef struct packed {
        logic             spc;
        logic             sif;
        logic             bub;
        logic             fl;
        logic             frz;
        logic             hlt;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t   expq[$];
    instr_t pipe[3];       // 0=EX, 1=MEM, 2=WB, each holding the accepted instruction
    bit     m_halted;
    int     m_cnt;
    int     total = 0;
    int     bad   = 0;

    task automatic step(input bit r, input int rx, input int ry, input bit ux, input bit uy,
                        input int ro, input bit wen, input bit ld, input bit hlt,
                        input bit redir, input bit busy);
        exp_t   e;
        instr_t nop;
        bit     hazard;
        bit     frz;
        @(negedge clk);
        rst             = r;
        hif.id_rX       = rx[REG_W-1:0];
        hif.id_rY       = ry[REG_W-1:0];
        hif.id_uses_x   = ux;
        hif.id_uses_y   = uy;
        hif.id_rO       = ro[REG_W-1:0];
        hif.id_rf_wen   = wen;
        hif.id_is_load  = ld;
        hif.id_is_halt  = hlt;
        hif.ex_redirect = redir;
        hif.mem_busy    = busy;

        nop    = '{0, 1'b0, 1'b0, 1'b0};
        hazard = pipe[0].ld && pipe[0].wen &&
                 ((ux && rx == pipe[0].rd) || (uy && ry == pipe[0].rd));
        frz    = m_halted || busy;
        e      = '0;
        if (!r) begin
            e.hlt = m_halted;
            e.cnt = m_cnt[CNT_W-1:0];
            if (frz) e.frz = 1'b1;
            else if (redir) begin e.fl = 1'b1; e.bub = 1'b1; end
            else if (hazard) begin e.spc = 1'b1; e.sif = 1'b1; e.bub = 1'b1; end
        end
        expq.push_back(e);

        if (r) begin
            pipe[0] = nop; pipe[1] = nop; pipe[2] = nop;
            m_halted = 1'b0;
            m_cnt = 0;
        end else if (!frz) begin
            if (pipe[2].hlt) m_halted = 1'b1;
            if (!redir && hazard && m_cnt < CNT_MAX) m_cnt++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (redir || hazard) ? nop : '{ro, wen, ld, hlt};
        end
    endtask

    task automatic idle(input bit busy);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, busy);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are valid every cycle, so each driven cycle yields one check.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            #4;
            if (expq.size() > 0) begin
                e     = expq.pop_front();
                a.spc = hif.stall_pc;
                a.sif = hif.stall_ifid;
                a.bub = hif.bubble_idex;
                a.fl  = hif.flush_ifid;
                a.frz = hif.freeze_all;
                a.hlt = hif.halted;
                a.cnt = hif.stall_cnt;
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t spc/sif/bub/fl/frz/hlt got=%b%b%b%b%b%b want=%b%b%b%b%b%b cnt got=%0d want=%0d",
                             $time, a.spc, a.sif, a.bub, a.fl, a.frz, a.hlt,
                             e.spc, e.sif, e.bub, e.fl, e.frz, e.hlt, a.cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        int drain;
        pipe[0] = '{0, 1'b0, 1'b0, 1'b0};
        pipe[1] = pipe[0];
        pipe[2] = pipe[0];
        m_halted = 1'b0;
        m_cnt    = 0;

        do_reset(); do_reset();

        // load r3 then read r3: exactly one bubble
        step(0, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
        step(0, 3, 0, 1, 0, 1, 1, 0, 0, 0, 0);
        step(0, 3, 0, 1, 0, 1, 1, 0, 0, 0, 0);
        idle(0); idle(0);

        // no false stall: unrelated regs, then ALU producer
        step(0, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
        step(0, 4, 5, 1, 1, 6, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        step(0, 3, 3, 1, 1, 6, 1, 0, 0, 0, 0);
        idle(0); idle(0);

        // redirect squashes a load-use
        step(0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0);
        step(0, 2, 0, 1, 0, 1, 1, 0, 0, 1, 0);
        idle(0); idle(0);

        // mem_busy over a load-use for 3 cycles, then one bubble
        step(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        repeat (3) step(0, 1, 0, 1, 0, 4, 1, 0, 0, 0, 1);
        step(0, 1, 0, 1, 0, 4, 1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 4, 1, 0, 0, 0, 0);
        idle(0); idle(0);

        // r0 is an ordinary register; load without wen is not a producer
        step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        step(0, 7, 0, 0, 1, 2, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 5, 0, 1, 0, 0, 0);
        step(0, 5, 0, 1, 0, 2, 1, 0, 0, 0, 0);
        idle(0);

        // reset in the middle of a stall
        step(0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
        step(1, 5, 0, 1, 0, 1, 1, 0, 0, 0, 0);
        step(0, 5, 0, 1, 0, 1, 1, 0, 0, 0, 0);
        idle(0);

        // HALT retires three edges after acceptance and freezes everything
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (6) idle(0);
        step(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0);
        do_reset();
        idle(0);

        // randomized traffic with a narrow register range to provoke hazards
        repeat (3000) begin
            step(($urandom_range(0, 149) == 0),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom), 1'($urandom), $urandom_range(0, 3),
                 1'($urandom), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
        end

        // counter saturation: back-to-back self-dependent loads, one stall per two cycles
        do_reset();
        repeat (2 * (CNT_MAX + 20)) step(0, 1, 0, 1, 0, 1, 1, 1, 0, 0, 0);
        idle(0);
        #4;
        total++;
        if (hif.stall_cnt !== CNT_W'(CNT_MAX)) begin
            bad++;
            $display("FAIL sat_cnt got=%0d want=%0d", hif.stall_cnt, CNT_MAX);
        end
        do_reset();
        idle(0);
        idle(0);

        drain = 0;
        while (expq.size() > 0 && drain < 20) begin
            @(negedge clk);
            drain++;
        end
        #6;
        if (expq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
